regfile_bist: RTL
=================

# regfile_bist

Built-in self-test engine for the 32x32 register file (two async read ports, one sync write port). It is the initiator side of that interface: it drives `we`/`wa`/`wd` and `ra1`/`ra2`, samples `rd1`/`rd2`, and reports pass/fail. It sits beside the RegFile in the datapath. The core muxes the BIST's write and read-address outputs onto the RegFile ports while `busy` is high.

## Interface
- `SEED`, default 32'hA5A5_5A5A: base data pattern.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle request; honoured only in IDLE.
- `busy` output 1: high from the cycle after `start` is accepted through the DONE cycle.
- `done` output 1: one-cycle pulse in the DONE state.
- `pass` output 1: result of the last completed run; held until the next accepted `start`.
- `fail_addr` output 5: register address of the first mismatch.
- `fail_data` output 32: observed read data at the first mismatch.
- `we` output 1: RegFile write enable.
- `wa` output 5: RegFile write address.
- `wd` output 32: RegFile write data.
- `ra1` output 5: RegFile read address, port 1.
- `ra2` output 5: RegFile read address, port 2.
- `rd1` input 32: RegFile read data, port 1 (combinational from `ra1`).
- `rd2` input 32: RegFile read data, port 2 (combinational from `ra2`).

## Operation
- **Patterns**
  - Pass 0 data: P0(a) = SEED ^ {27'b0, a}.
  - Pass 1 data: P1(a) = ~P0(a).
  - Expected read value E(a) = 0 when a == 0, else the current pass pattern.
- **States**
  - IDLE: accept `start`, then go to W0.
  - W0: 32 cycles, counter a = 0..31. Drive `we`=1, `wa`=a, `wd`=P0(a). Register x0 is written too, to test hardwired zero.
  - R0: 16 cycles, i = 0..15. Drive `ra1`=2i and `ra2`=2i+1. Compare against E using P0.
  - W1: as W0, using P1.
  - R1: as R0, using P1.
  - DONE: `done`=1 for one cycle, then return to IDLE.
- **Outputs**
  - All BIST-side outputs (`we`, `wa`, `wd`, `ra1`, `ra2`) come from registers. No combinational path from `start` to any output.
  - `we`=0 in every state except W0 and W1.
- **Compare and error capture**
  - `rd1`/`rd2` are compared in the same cycle the addresses are driven; the result is captured at the clock edge.
  - Only the first mismatch of a run is captured in `fail_addr`/`fail_data`.
  - If both ports mismatch in the same cycle, port 1 is reported.
  - The run always completes; there is no early abort, so latency is fixed.
- **Result flags**
  - `pass` is set to 1 in DONE only if the run saw no mismatch.
  - On an accepted `start`, `pass`, `fail_addr` and `fail_data` are cleared to 0.
- `start` is ignored while busy, including in the DONE cycle.

## Timing
- **Reset (async):**
  - `we`=0, `wa`=0, `wd`=0, `ra1`=0, `ra2`=0.
  - `busy`=0, `done`=0, `pass`=0, `fail_addr`=0, `fail_data`=0.
  - State returns to IDLE.
  - Takes effect immediately, mid-run included. `we` must drop without waiting for `clk`.
- **Run latency:** with `start` sampled at edge 0:
  - W0 occupies cycles 1-32.
  - R0 occupies cycles 33-48.
  - W1 occupies cycles 49-80.
  - R1 occupies cycles 81-96.
  - `done`=1 in cycle 97.
  - `busy` is high in cycles 1-97.
- RegFile writes commit on the edge that ends each W cycle. The first R cycle therefore sees all 32 writes.
- Counters wrap from 31 (W) or 15 (R) to 0 at each phase change. They never run past their phase.

## Test plan
- **Fault-free run:** real RegFile, `start` pulse. Require `done` exactly 97 cycles later, `pass`=1, `fail_addr`=0, `fail_data`=0, and `busy` high for exactly 97 cycles.
- **Stuck-at fault:** RegFile model with x7 bit 3 stuck at 0. Require `pass`=0, `fail_addr`=7, `fail_data`=32'hA5A5_5A55 (captured in pass 0).
- **x0 not hardwired:** model where x0 stores writes. Require `pass`=0, `fail_addr`=0, `fail_data`=32'hA5A5_5A5A.
- **Busy-time `start`:** pulse `start` at cycles 10 and 97 (DONE). Require both ignored, exactly one `done` pulse, and no restart.
- **Reset mid-run:** assert `rst_n`=0 at cycle 40 between edges. Require `we`=0 and `busy`=0 immediately. After release and a new `start`, require a full 97-cycle run with `pass`=1.
- **Result persistence:** after a failing run, apply a new `start`. Require `pass`, `fail_addr` and `fail_data` cleared on the next edge; a fault-free second run then ends with `pass`=1.

Source files
------------

// File: rtl/regfile_bist.sv
// regfile_bist: built-in self-test engine for a 32x32 register file that has two
// asynchronous read ports and one synchronous write port.
//
// It writes a seed-derived pattern to every register, reads all of them back on
// both ports, and then repeats the write and read with the inverted pattern.
// It reports pass/fail along with the first mismatching address and data.
// Register x0 is written like the others, and it must still read back as zero.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                one-cycle run request (honoured only when idle)
//   busy, done           run in progress / one-cycle completion pulse
//   pass                 result of the last completed run
//   fail_addr, fail_data address and observed data of the first mismatch
//   we, wa, wd           register-file write port (registered)
//   ra1, ra2             register-file read addresses (registered)
//   rd1, rd2             register-file read data (combinational from ra1/ra2)
module regfile_bist #(
    parameter logic [31:0] SEED = 32'hA5A5_5A5A
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  fail_addr,
    output logic [31:0] fail_data,
    output logic        we,
    output logic [4:0]  wa,
    output logic [31:0] wd,
    output logic [4:0]  ra1,
    output logic [4:0]  ra2,
    input  logic [31:0] rd1,
    input  logic [31:0] rd2
);

    typedef enum logic [2:0] {StIdle, StW0, StR0, StW1, StR1, StDone} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d, done_q, done_d, pass_q, pass_d, err_q, err_d;
    logic [4:0]  fail_addr_q, fail_addr_d;
    logic [31:0] fail_data_q, fail_data_d;
    logic        we_q, we_d;
    logic [4:0]  wa_q, wa_d, ra1_q, ra1_d, ra2_q, ra2_d;
    logic [31:0] wd_q, wd_d;
    logic        in_read, rd_phase_d, mis1, mis2;
    logic [31:0] exp1, exp2;

    function automatic logic [31:0] pattern(input logic inv, input logic [4:0] a);
        logic [31:0] p;
        p = SEED ^ {27'b0, a};
        return inv ? ~p : p;
    endfunction

    // Next state and phase counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StW0;
                    cnt_d   = 5'd0;
                end
            end
            StW0: begin
                if (cnt_q == 5'd31) begin
                    state_d = StR0;
                    cnt_d   = 5'd0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            StR0: begin
                if (cnt_q == 5'd15) begin
                    state_d = StW1;
                    cnt_d   = 5'd0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            StW1: begin
                if (cnt_q == 5'd31) begin
                    state_d = StR1;
                    cnt_d   = 5'd0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            StR1: begin
                if (cnt_q == 5'd15) begin
                    state_d = StDone;
                    cnt_d   = 5'd0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
                cnt_d   = 5'd0;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 5'd0;
            end
        endcase
    end

    // Compare the read data against the addresses driven in this cycle.
    always_comb begin
        in_read = (state_q == StR0) || (state_q == StR1);
        exp1    = (ra1_q == 5'd0) ? 32'd0 : pattern(state_q == StR1, ra1_q);
        exp2    = (ra2_q == 5'd0) ? 32'd0 : pattern(state_q == StR1, ra2_q);
        mis1    = in_read && (rd1 != exp1);
        mis2    = in_read && (rd2 != exp2);
    end

    // The outputs are computed from the next state, so every output is a plain flop.
    always_comb begin
        we_d        = (state_d == StW0) || (state_d == StW1);
        wa_d        = we_d ? cnt_d : 5'd0;
        wd_d        = we_d ? pattern(state_d == StW1, cnt_d) : 32'd0;
        rd_phase_d  = (state_d == StR0) || (state_d == StR1);
        ra1_d       = rd_phase_d ? {cnt_d[3:0], 1'b0} : 5'd0;
        ra2_d       = rd_phase_d ? {cnt_d[3:0], 1'b1} : 5'd0;
        busy_d      = (state_d != StIdle);
        done_d      = (state_d == StDone);
        pass_d      = pass_q;
        err_d       = err_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        if ((state_q == StIdle) && start) begin
            pass_d      = 1'b0;
            err_d       = 1'b0;
            fail_addr_d = 5'd0;
            fail_data_d = 32'd0;
        end else if (!err_q && (mis1 || mis2)) begin
            // Port 1 wins when both ports miss in the same cycle.
            err_d       = 1'b1;
            fail_addr_d = mis1 ? ra1_q : ra2_q;
            fail_data_d = mis1 ? rd1 : rd2;
        end
        // The final R1 compare lands on the same edge that enters DONE.
        if (state_d == StDone) begin
            pass_d = !(err_q || mis1 || mis2);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= 5'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= 1'b0;
            fail_addr_q <= 5'd0;
            fail_data_q <= 32'd0;
            we_q        <= 1'b0;
            wa_q        <= 5'd0;
            wd_q        <= 32'd0;
            ra1_q       <= 5'd0;
            ra2_q       <= 5'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_q       <= err_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            we_q        <= we_d;
            wa_q        <= wa_d;
            wd_q        <= wd_d;
            ra1_q       <= ra1_d;
            ra2_q       <= ra2_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
    assign we        = we_q;
    assign wa        = wa_q;
    assign wd        = wd_q;
    assign ra1       = ra1_q;
    assign ra2       = ra2_q;

endmodule
